// File: rtl/alu_decode_stage.sv
// ALU decode stage: decodes alu_op/op/funct3/funct7 into ALU control and memory
// attributes, buffered in a small in-order FIFO. Define ALU_DECODE_ILLEGAL_EN for illegal-encoding detection.
module alu_decode_stage #(
  parameter int unsigned ALUOP_WIDTH = 3,
  parameter int unsigned OP_WIDTH    = 7,
  parameter int unsigned F3_WIDTH    = 3,
  parameter int unsigned F7_WIDTH    = 7,
  parameter int unsigned CTRL_WIDTH  = 4,
  parameter int unsigned DEPTH       = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ALUOP_WIDTH-1:0] alu_op,
  input  logic [OP_WIDTH-1:0]    op,
  input  logic [F3_WIDTH-1:0]    funct3,
  input  logic [F7_WIDTH-1:0]    funct7,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_WIDTH-1:0]  alu_ctrl,
  output logic [1:0]             mem_size,
  output logic                   mem_unsigned,
  output logic                   illegal,
  output logic                   err_sticky,
  output logic [2:0]             level
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SLOTS = 1 << PTR_W;
  localparam int unsigned LVL_W = 3;

  localparam logic [3:0] C_ADD   = 4'b0000;
  localparam logic [3:0] C_SUB   = 4'b1000;
  localparam logic [3:0] C_SLL   = 4'b0001;
  localparam logic [3:0] C_SLT   = 4'b0010;
  localparam logic [3:0] C_SLTU  = 4'b0011;
  localparam logic [3:0] C_XOR   = 4'b0100;
  localparam logic [3:0] C_SRL   = 4'b0101;
  localparam logic [3:0] C_SRA   = 4'b1101;
  localparam logic [3:0] C_OR    = 4'b0110;
  localparam logic [3:0] C_AND   = 4'b0111;
  localparam logic [3:0] C_PASSB = 4'b1001;

  logic [3:0]       dec_ctrl;
  logic [1:0]       dec_size;
  logic             dec_uns;
  logic             dec_ill;

  logic [3:0]       ctrl_q [SLOTS];
  logic [3:0]       ctrl_d [SLOTS];
  logic [1:0]       size_q [SLOTS];
  logic [1:0]       size_d [SLOTS];
  logic             uns_q  [SLOTS];
  logic             uns_d  [SLOTS];
  logic             ill_q  [SLOTS];
  logic             ill_d  [SLOTS];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;
  logic             push, pop;
  logic             unused_fields;

  assign unused_fields = ^{op, funct3, funct7};

`ifdef ALU_DECODE_ILLEGAL_EN
  logic f7_zero, f7_alt;
  assign f7_zero = (funct7 == '0);
  assign f7_alt  = (funct7 == F7_WIDTH'(7'h20));
`endif

  // Decode of the incoming request
  always_comb begin
    dec_ctrl = C_ADD;
    dec_size = 2'd0;
    dec_uns  = 1'b0;
    dec_ill  = 1'b0;
    case (alu_op)
      ALUOP_WIDTH'(0): begin
        case (funct3[2:0])
          3'b000:  dec_ctrl = (op[5] && funct7[5]) ? C_SUB : C_ADD;
          3'b001:  dec_ctrl = C_SLL;
          3'b010:  dec_ctrl = C_SLT;
          3'b011:  dec_ctrl = C_SLTU;
          3'b100:  dec_ctrl = C_XOR;
          3'b101:  dec_ctrl = funct7[5] ? C_SRA : C_SRL;
          3'b110:  dec_ctrl = C_OR;
          default: dec_ctrl = C_AND;
        endcase
      end
      ALUOP_WIDTH'(1): begin
        dec_size = funct3[1:0];
        dec_uns  = funct3[2];
      end
      ALUOP_WIDTH'(2): dec_size = funct3[1:0];
      ALUOP_WIDTH'(3): begin
        case (funct3[2:1])
          2'b10:   dec_ctrl = C_SLT;
          2'b11:   dec_ctrl = C_SLTU;
          default: dec_ctrl = C_SUB;
        endcase
      end
      ALUOP_WIDTH'(5): dec_ctrl = C_PASSB;
      default:         dec_ctrl = C_ADD;
    endcase
`ifdef ALU_DECODE_ILLEGAL_EN
    case (alu_op)
      ALUOP_WIDTH'(0): begin
        if (op[5] && !f7_zero && !f7_alt) dec_ill = 1'b1;
        if (op[5] && f7_alt && funct3[2:0] != 3'b000 && funct3[2:0] != 3'b101) dec_ill = 1'b1;
        if (!op[5] && funct3[2:0] == 3'b001 && !f7_zero) dec_ill = 1'b1;
      end
      ALUOP_WIDTH'(1): dec_ill = (funct3[2:0] == 3'b011) || (funct3[2:1] == 2'b11);
      ALUOP_WIDTH'(2): dec_ill = (funct3[2:0] >= 3'b011);
      ALUOP_WIDTH'(3): dec_ill = (funct3[2:1] == 2'b01);
      default:         dec_ill = 1'b0;
    endcase
    // Illegal entries carry a neutral payload
    if (dec_ill) begin
      dec_ctrl = C_ADD;
      dec_size = 2'd0;
      dec_uns  = 1'b0;
    end
`endif
  end

  // Buffer bookkeeping; in_ready depends only on occupancy, never on out_ready
  always_comb begin
    push        = in_valid && in_ready_q;
    pop         = out_valid_q && out_ready;
    ctrl_d      = ctrl_q;
    size_d      = size_q;
    uns_d       = uns_q;
    ill_d       = ill_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    err_d       = err_q;
    if (push) begin
      ctrl_d[wr_ptr_q] = dec_ctrl;
      size_d[wr_ptr_q] = dec_size;
      uns_d[wr_ptr_q]  = dec_uns;
      ill_d[wr_ptr_q]  = dec_ill;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      err_d    = err_q | dec_ill;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    level_d     = level_q + LVL_W'(push) - LVL_W'(pop);
    in_ready_d  = (level_d < LVL_W'(DEPTH));
    out_valid_d = (level_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SLOTS); i++) begin
        ctrl_q[i] <= '0;
        size_q[i] <= '0;
        uns_q[i]  <= 1'b0;
        ill_q[i]  <= 1'b0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      ill_q       <= ill_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  // Head entry is forced to zero while the buffer is empty
  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign level        = level_q;
  assign alu_ctrl     = out_valid_q ? CTRL_WIDTH'(ctrl_q[rd_ptr_q]) : '0;
  assign mem_size     = out_valid_q ? size_q[rd_ptr_q] : 2'd0;
  assign mem_unsigned = out_valid_q && uns_q[rd_ptr_q];
  assign illegal      = out_valid_q && ill_q[rd_ptr_q];
  assign err_sticky   = err_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: directed steps plus a random phase,
// checked against an independent decode model.
module tb_alu_decode_stage;
  localparam int unsigned DEPTH = 2;
  localparam logic [6:0] OP_R = 7'b0110011;

  typedef struct packed {
    logic [3:0] ctrl;
    logic [1:0] size;
    logic       uns;
    logic       ill;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] alu_op = '0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] alu_ctrl;
  logic [1:0] mem_size;
  logic       mem_unsigned;
  logic       illegal;
  logic       err_sticky;
  logic [2:0] level;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic err_exp = 1'b0;

`ifdef ALU_DECODE_ILLEGAL_EN
  localparam logic ILL_EN = 1'b1;
`else
  localparam logic ILL_EN = 1'b0;
`endif

  alu_decode_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .op(op), .funct3(funct3), .funct7(funct7),
    .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .illegal(illegal),
    .err_sticky(err_sticky), .level(level)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  function automatic exp_t model(input logic [2:0] aop, input logic [6:0] opv,
                                 input logic [2:0] f3, input logic [6:0] f7);
    exp_t r;
    logic bad;
    r = '0;
    bad = 1'b0;
    case (aop)
      3'd0: begin
        if (f3 == 3'b000)      r.ctrl = (opv[5] && f7[5]) ? 4'b1000 : 4'b0000;
        else if (f3 == 3'b101) r.ctrl = f7[5] ? 4'b1101 : 4'b0101;
        else                   r.ctrl = {1'b0, f3};
      end
      3'd1: begin r.size = f3[1:0]; r.uns = f3[2]; end
      3'd2: r.size = f3[1:0];
      3'd3: r.ctrl = f3[2] ? (f3[1] ? 4'b0011 : 4'b0010) : 4'b1000;
      3'd5: r.ctrl = 4'b1001;
      default: r.ctrl = 4'b0000;
    endcase
    if (ILL_EN) begin
      bad = (aop == 3'd1 && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) ||
            (aop == 3'd2 && f3 >= 3'd3) ||
            (aop == 3'd3 && (f3 == 3'd2 || f3 == 3'd3)) ||
            (aop == 3'd0 && opv[5] && f7 != 7'h00 && f7 != 7'h20) ||
            (aop == 3'd0 && opv[5] && f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5) ||
            (aop == 3'd0 && !opv[5] && f3 == 3'd1 && f7 != 7'h00);
      if (bad) r = '{ctrl: 4'b0000, size: 2'd0, uns: 1'b0, ill: 1'b1};
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs at negedge, check head/state, update scoreboard.
  task automatic step(input logic v, input logic [2:0] aop, input logic [6:0] opv,
                      input logic [2:0] f3, input logic [6:0] f7, input logic ordy);
    exp_t e;
    int   n;
    @(negedge clk);
    in_valid = v; alu_op = aop; op = opv; funct3 = f3; funct7 = f7; out_ready = ordy;
    #1;
    n = exp_q.size();
    chk("level", 32'(level), 32'(n));
    chk("in_ready", 32'(in_ready), 32'(n < int'(DEPTH)));
    chk("out_valid", 32'(out_valid), 32'(n != 0));
    chk("err_sticky", 32'(err_sticky), 32'(err_exp));
    if (n == 0) begin
      chk("idle_data", 32'({alu_ctrl, mem_size, mem_unsigned, illegal}), 32'(0));
    end else begin
      e = exp_q[0];
      chk("head", 32'({alu_ctrl, mem_size, mem_unsigned, illegal}), 32'(e));
    end
    if (n != 0 && ordy) void'(exp_q.pop_front());
    if (v && n < int'(DEPTH)) begin
      e = model(aop, opv, f3, f7);
      exp_q.push_back(e);
      err_exp = err_exp | e.ill;
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_level", 32'(level), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_err", 32'(err_sticky), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // SUB decode, 1-cycle latency
    step(1'b1, 3'd0, OP_R, 3'b000, 7'b0100000, 1'b1);
    step(1'b0, 3'd0, OP_R, 3'b000, 7'b0000000, 1'b1);
    chk("sub_ctrl", 32'(alu_ctrl), 32'h8);
    chk("sub_level", 32'(level), 32'(1));

    // Fill with stalled consumer, third request held, then drain in order
    step(1'b1, 3'd0, OP_R, 3'b000, 7'b0000000, 1'b0);
    step(1'b1, 3'd0, OP_R, 3'b000, 7'b0100000, 1'b0);
    step(1'b1, 3'd0, OP_R, 3'b100, 7'b0000000, 1'b0);
    chk("full_level", 32'(level), 32'(2));
    chk("full_in_ready", 32'(in_ready), 32'(0));
    step(1'b1, 3'd0, OP_R, 3'b100, 7'b0000000, 1'b0);
    chk("stall_head", 32'(alu_ctrl), 32'h0);
    step(1'b1, 3'd0, OP_R, 3'b100, 7'b0000000, 1'b1);
    chk("pop_full_in_ready", 32'(in_ready), 32'(0));
    chk("order_add", 32'(alu_ctrl), 32'h0);
    step(1'b1, 3'd0, OP_R, 3'b100, 7'b0000000, 1'b1);
    chk("after_pop_level", 32'(level), 32'(1));
    chk("after_pop_in_ready", 32'(in_ready), 32'(1));
    chk("order_sub", 32'(alu_ctrl), 32'h8);
    step(1'b0, 3'd0, OP_R, 3'b000, 7'b0000000, 1'b1);
    chk("order_xor", 32'(alu_ctrl), 32'h4);

    // Unsigned byte load and LUI
    step(1'b1, 3'd1, 7'b0000011, 3'b100, 7'b0000000, 1'b1);
    step(1'b1, 3'd5, 7'b0110111, 3'b000, 7'b0000000, 1'b1);
    chk("lbu", 32'({alu_ctrl, mem_size, mem_unsigned}), 32'({4'b0000, 2'd0, 1'b1}));
    step(1'b0, 3'd0, OP_R, 3'b000, 7'b0000000, 1'b1);
    chk("lui", 32'(alu_ctrl), 32'h9);

    // Store with funct3=100
    step(1'b1, 3'd2, 7'b0100011, 3'b100, 7'b0000000, 1'b0);
    step(1'b0, 3'd0, OP_R, 3'b000, 7'b0000000, 1'b1);
    chk("store_illegal", 32'(illegal), 32'(ILL_EN));
    step(1'b0, 3'd0, OP_R, 3'b000, 7'b0000000, 1'b0);
    chk("sticky_after_pop", 32'(err_sticky), 32'(ILL_EN));

    // Asynchronous reset with two entries buffered
    step(1'b1, 3'd0, OP_R, 3'b110, 7'b0000000, 1'b0);
    step(1'b1, 3'd0, OP_R, 3'b111, 7'b0000000, 1'b0);
    step(1'b0, 3'd0, OP_R, 3'b000, 7'b0000000, 1'b0);
    chk("pre_rst_level", 32'(level), 32'(2));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'(0));
    chk("arst_level", 32'(level), 32'(0));
    chk("arst_in_ready", 32'(in_ready), 32'(1));
    chk("arst_data", 32'({alu_ctrl, mem_size, mem_unsigned, illegal, err_sticky}), 32'(0));
    exp_q.delete();
    err_exp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; alu_op = 3'd0; op = OP_R; funct3 = 3'b100; funct7 = 7'b0; out_ready = 1'b0;
    exp_q.push_back(model(3'd0, OP_R, 3'b100, 7'b0));
    step(1'b0, 3'd0, OP_R, 3'b000, 7'b0000000, 1'b1);
    chk("first_after_rst", 32'(alu_ctrl), 32'h4);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      logic [6:0] f7r;
      case ($urandom_range(0, 2))
        0:       f7r = 7'h00;
        1:       f7r = 7'h20;
        default: f7r = 7'($urandom);
      endcase
      step(1'($urandom), 3'($urandom), 7'($urandom), 3'($urandom), f7r,
           ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < int'(DEPTH) + 2; i++) begin
      step(1'b0, 3'd0, OP_R, 3'b000, 7'b0000000, 1'b1);
    end
    chk("drained", 32'(level), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_decode_stage.md
ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 The block SHALL have parameter ALUOP_WIDTH, default 3, meaning width of the alu_op type field.
REQ-002 The block SHALL have parameter OP_WIDTH, default 7, meaning opcode width.
REQ-003 The block SHALL have parameter F3_WIDTH, default 3, meaning funct3 width.
REQ-004 The block SHALL have parameter F7_WIDTH, default 7, meaning funct7 width.
REQ-005 The block SHALL have parameter CTRL_WIDTH, default 4, meaning ALU control width, minimum 4.
REQ-006 The block SHALL have parameter DEPTH, default 2, meaning output buffer entries, legal values 1 to 4.
REQ-007 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
REQ-008 clk  in  1  rising-edge clock.
REQ-009 rst_n  in  1  asynchronous active-low reset.
REQ-010 in_valid  in  1  decode request present.
REQ-011 in_ready  out  1  request accepted this cycle when high with in_valid.
REQ-012 alu_op  in  ALUOP_WIDTH  type: 0 RIALU, 1 I-load, 2 S, 3 B, 4 U-AUIPC, 5 U-LUI, 6 JALR, 7 JAL.
REQ-013 op, funct3, funct7  in  OP_WIDTH/F3_WIDTH/F7_WIDTH  instruction fields.
REQ-014 out_valid  out  1  head entry valid.
REQ-015 out_ready  in  1  consumer takes head entry when high with out_valid.
REQ-016 alu_ctrl  out  CTRL_WIDTH  ALU operation of the head entry.
REQ-017 mem_size  out  2  0 byte, 1 half, 2 word.
REQ-018 mem_unsigned  out  1  zero-extend load.
REQ-019 illegal  out  1  head entry is an illegal encoding.
REQ-020 err_sticky  out  1  an illegal entry has been accepted since reset.
REQ-021 level  out  3  number of occupied buffer entries.

Function
REQ-022 The alu_ctrl encoding SHALL be: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111, PASSB 1001; upper bits above bit 3 are zero.
REQ-023 RIALU SHALL decode by funct3: 000 SUB if op[5] and funct7[5] else ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRA if funct7[5] else SRL; 110 OR; 111 AND.
REQ-024 I-load SHALL give ADD, mem_size=funct3[1:0], mem_unsigned=funct3[2]; S SHALL give ADD, mem_size=funct3[1:0], mem_unsigned=0.
REQ-025 B SHALL give SUB for funct3 00x, SLT for 10x, SLTU for 11x; AUIPC, JALR, JAL SHALL give ADD; LUI SHALL give PASSB.
REQ-026 Non-memory types SHALL output mem_size=0, mem_unsigned=0; no output SHALL ever be X.
REQ-027 in_ready SHALL equal (level < DEPTH), registered-only, with no combinational path from out_ready.
REQ-028 An accepted request SHALL be decoded and written to the buffer tail, appearing on the outputs no earlier than the next cycle (1-cycle latency when empty).
REQ-029 Entries SHALL leave in acceptance order; push and pop in the same cycle SHALL leave level unchanged.
REQ-030 When level is 0, out_valid SHALL be 0 and alu_ctrl, mem_size, mem_unsigned, illegal SHALL be 0.
REQ-031 Head outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-032 Pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or underflow.

Reset
REQ-033 On rst_n low, level, pointers, out_valid, err_sticky and all data outputs SHALL clear to 0 immediately; in_ready SHALL be 1.
REQ-034 Reset mid-operation SHALL discard all buffered entries; first acceptance SHALL be possible on the first clk edge after rst_n rises.

Configuration
REQ-035 Macro ALU_DECODE_ILLEGAL_EN SHALL compile in illegal-encoding detection.
REQ-036 With it defined: illegal=1 for load funct3 011/110/111, store funct3 >= 011, branch funct3 010/011, R-type (op[5]=1) funct7 not 0x00/0x20, SUB/SRA funct7 on other funct3, or SLLI with funct7 != 0; such entries carry alu_ctrl=ADD, mem_size=0; err_sticky sets on acceptance and holds until reset.
REQ-037 Without it: illegal and err_sticky SHALL be tied 0 and those encodings SHALL decode per REQ-023 to REQ-025.

Verification
REQ-038 Reset, then alu_op=0, op=0110011, funct3=000, funct7=0100000, out_ready=1 -> next cycle out_valid=1, alu_ctrl=1000, level=1.
REQ-039 out_ready=0, push 3 requests with DEPTH=2 -> level=2, in_ready=0 after two, third held; release -> ADD/SUB order preserved.
REQ-040 alu_op=1, funct3=100 -> mem_size=0, mem_unsigned=1, alu_ctrl=0000; alu_op=5 -> alu_ctrl=1001.
REQ-041 Full buffer, simultaneous pop and in_valid -> in_ready=0 that cycle; level 2 -> 1; next cycle accept.
REQ-042 With ALU_DECODE_ILLEGAL_EN, alu_op=2, funct3=100 -> illegal=1, err_sticky=1 persists after pop; without macro -> illegal=0.
REQ-043 rst_n pulsed low with level=2 -> out_valid=0, level=0 asynchronously, in_ready=1.
